// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states, datapath widths and the
// {pc, inst} payload carried through the fetch buffer.
package cpu_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned FETCH_DEPTH = 2;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, inst} pairs between instruction memory and
// decode. Flush empties it in one edge; the head is read straight from storage.
module fetch_buffer
  import cpu_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  fetch_entry_t i_push_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [1:0]   o_count,
  output fetch_entry_t o_head
);

  fetch_entry_t r_mem [FETCH_DEPTH];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(FETCH_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + 2'(i_push) - 2'(i_pop);
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the next PC, issues one word request at a time
// over req/gnt/rvalid and buffers returned instructions for decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [XLEN-1:0]   i_pc,
  output logic [XLEN-1:0]   o_pc_next,
  input  logic              i_redirect,
  input  logic [XLEN-1:0]   i_redirect_addr,
  output logic              o_imem_req,
  output logic [XLEN-1:0]   o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_rvalid,
  input  logic [INST_W-1:0] i_imem_rdata,
  output logic              o_inst_valid,
  output logic [INST_W-1:0] o_inst,
  output logic [XLEN-1:0]   o_inst_pc,
  input  logic              i_inst_ready
);

  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [XLEN-1:0] r_req_addr;
  logic [XLEN-1:0] r_req_pc;
  logic            r_drop;
  logic            w_drop_next;
  logic            w_issue;
  logic            w_issue_ok;
  logic            w_resp;
  logic            w_push;
  logic            w_pop;
  logic [1:0]      w_count;
  logic [1:0]      w_count_after;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_data;

  // A response coinciding with a redirect belongs to the old path and is dropped.
  assign w_resp        = (r_state == WAIT) && i_imem_rvalid;
  assign w_push        = w_resp && !r_drop && !i_redirect;
  assign w_pop         = o_inst_valid && i_inst_ready;
  assign w_count_after = w_count + 2'(w_push) - 2'(w_pop);
  assign w_issue_ok    = !i_redirect && (w_count_after < 2'd2);
  assign w_push_data   = '{pc: r_req_pc, inst: i_imem_rdata};

  always_comb begin
    w_state_next = r_state;
    w_drop_next  = r_drop;
    w_issue      = 1'b0;
    case (r_state)
      IDLE: w_issue = w_issue_ok;
      REQ: begin
        if (i_imem_gnt) begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (i_imem_rvalid) begin
          w_drop_next  = 1'b0;
          w_issue      = w_issue_ok;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (w_issue) begin
      w_state_next = REQ;
    end
    // Only a request still outstanding after this cycle needs its data dropped.
    if (i_redirect && ((r_state == REQ) || ((r_state == WAIT) && !i_imem_rvalid))) begin
      w_drop_next = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_drop     <= 1'b0;
      r_req_addr <= '0;
      r_req_pc   <= RESET_ADDR;
    end else begin
      r_state <= w_state_next;
      r_drop  <= w_drop_next;
      if (w_issue) begin
        r_req_addr <= i_pc & WORD_MASK;
        r_req_pc   <= i_pc;
      end
    end
  end

  always_comb begin
    o_pc_next = i_pc;
    if (i_rst) begin
      o_pc_next = i_pc;
    end else if (i_redirect) begin
      o_pc_next = i_redirect_addr & WORD_MASK;
    end else if (w_issue) begin
      o_pc_next = i_pc + PC_STEP;
    end
  end

  fetch_buffer u_buf (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (i_redirect),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  assign o_imem_req   = (r_state == REQ);
  assign o_imem_addr  = r_req_addr;
  assign o_inst_valid = (w_count != 2'd0);
  assign o_inst       = w_head.inst;
  assign o_inst_pc    = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: models the pc register and a memory that
// answers addr ^ 32'hDEAD0000 one cycle after gnt, with gnt/rvalid gating knobs.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'h0000_1000;
  logic [31:0] pc_next;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b1;

  logic        gnt_en = 1'b1;
  logic        rv_en = 1'b1;
  logic        pend = 1'b0;
  logic [31:0] pdata = 32'h0;

  int n_chk  = 0;
  int n_pass = 0;

  fetch_unit #(.RESET_ADDR(32'h0000_1000)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_pc            (pc),
    .o_pc_next       (pc_next),
    .i_redirect      (redirect),
    .i_redirect_addr (redirect_addr),
    .o_imem_req      (imem_req),
    .o_imem_addr     (imem_addr),
    .i_imem_gnt      (imem_gnt),
    .i_imem_rvalid   (imem_rvalid),
    .i_imem_rdata    (imem_rdata),
    .o_inst_valid    (inst_valid),
    .o_inst          (inst),
    .o_inst_pc       (inst_pc),
    .i_inst_ready    (inst_ready)
  );

  always #5 clk = ~clk;

  // pc register model
  always @(posedge clk) pc <= rst ? 32'h0000_1000 : pc_next;

  // memory model: one outstanding word, not reset with the fetch unit
  assign imem_gnt    = imem_req & gnt_en;
  assign imem_rvalid = pend & rv_en;
  assign imem_rdata  = pdata;
  always @(posedge clk) begin
    if (imem_req && imem_gnt) begin
      pend  <= 1'b1;
      pdata <= imem_addr ^ 32'hDEAD_0000;
    end else if (imem_rvalid) begin
      pend <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready_v);
    rst = 1'b1;
    gnt_en = 1'b1;
    rv_en = 1'b1;
    redirect = 1'b0;
    inst_ready = ready_v;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // reset values
    cyc();
    cyc();
    #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_pc_next", pc_next, 32'h0000_1000);

    // zero-wait streaming, decode always ready
    do_reset(1'b1);
    chk("s1_c0_pc_next", pc_next, 32'h0000_1004);
    chk("s1_c0_req", 32'(imem_req), 32'h0);
    cyc(); #1;
    chk("s1_c1_req", 32'(imem_req), 32'h1);
    chk("s1_c1_addr", imem_addr, 32'h0000_1000);
    cyc(); #1;
    chk("s1_c2_valid", 32'(inst_valid), 32'h0);
    chk("s1_c2_pc_next", pc_next, 32'h0000_1008);
    cyc(); #1;
    chk("s1_c3_valid", 32'(inst_valid), 32'h1);
    chk("s1_c3_inst_pc", inst_pc, 32'h0000_1000);
    chk("s1_c3_inst", inst, 32'hDEAD_1000);
    cyc(); #1;
    chk("s1_c4_valid", 32'(inst_valid), 32'h0);
    cyc(); #1;
    chk("s1_c5_inst_pc", inst_pc, 32'h0000_1004);
    chk("s1_c5_inst", inst, 32'hDEAD_1004);
    cyc(); cyc(); #1;
    chk("s1_c7_inst_pc", inst_pc, 32'h0000_1008);
    chk("s1_c7_inst", inst, 32'hDEAD_1008);

    // decode stalled: two entries buffered, fetch stops, then resumes in order
    do_reset(1'b0);
    repeat (5) cyc();
    #1;
    chk("s2_full_valid", 32'(inst_valid), 32'h1);
    chk("s2_full_head", inst_pc, 32'h0000_1000);
    chk("s2_full_pc_next", pc_next, 32'h0000_1008);
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      chk("s2_stall_req", 32'(imem_req), 32'h0);
    end
    chk("s2_stall_head", inst_pc, 32'h0000_1000);
    chk("s2_stall_pc", pc, 32'h0000_1008);
    cyc();
    inst_ready = 1'b1;
    #1;
    chk("s2_rel_head", inst_pc, 32'h0000_1000);
    chk("s2_rel_pc_next", pc_next, 32'h0000_100C);
    cyc(); #1;
    chk("s2_second", inst_pc, 32'h0000_1004);
    chk("s2_req", 32'(imem_req), 32'h1);
    chk("s2_req_addr", imem_addr, 32'h0000_1008);
    cyc(); #1;
    chk("s2_drained", 32'(inst_valid), 32'h0);
    cyc(); #1;
    chk("s2_third_pc", inst_pc, 32'h0000_1008);
    chk("s2_third_inst", inst, 32'hDEAD_1008);

    // redirect in WAIT for 1004 while its response arrives
    do_reset(1'b0);
    repeat (4) cyc();
    redirect = 1'b1;
    redirect_addr = 32'h0000_2002;
    #1;
    chk("s3_pre_valid", 32'(inst_valid), 32'h1);
    chk("s3_pc_next", pc_next, 32'h0000_2000);
    cyc();
    redirect = 1'b0;
    inst_ready = 1'b1;
    #1;
    chk("s3_flushed", 32'(inst_valid), 32'h0);
    chk("s3_issue_pc_next", pc_next, 32'h0000_2004);
    cyc(); #1;
    chk("s3_req_addr", imem_addr, 32'h0000_2000);
    cyc(); cyc(); #1;
    chk("s3_inst_pc", inst_pc, 32'h0000_2000);
    chk("s3_inst", inst, 32'hDEAD_2000);

    // redirect while REQ is held without gnt
    do_reset(1'b1);
    cyc();
    gnt_en = 1'b0;
    redirect = 1'b1;
    redirect_addr = 32'h0000_2002;
    #1;
    chk("s4_pc_next", pc_next, 32'h0000_2000);
    chk("s4_addr_c1", imem_addr, 32'h0000_1000);
    cyc();
    redirect = 1'b0;
    #1;
    chk("s4_addr_c2", imem_addr, 32'h0000_1000);
    chk("s4_req_c2", 32'(imem_req), 32'h1);
    cyc(); #1;
    chk("s4_addr_c3", imem_addr, 32'h0000_1000);
    cyc();
    gnt_en = 1'b1;
    #1;
    chk("s4_addr_c4", imem_addr, 32'h0000_1000);
    cyc(); #1;
    chk("s4_drop_valid", 32'(inst_valid), 32'h0);
    chk("s4_issue_pc_next", pc_next, 32'h0000_2004);
    cyc(); #1;
    chk("s4_req_addr", imem_addr, 32'h0000_2000);
    chk("s4_still_empty", 32'(inst_valid), 32'h0);
    cyc(); cyc(); #1;
    chk("s4_inst_pc", inst_pc, 32'h0000_2000);

    // PC wrap at the top of the address space
    do_reset(1'b1);
    redirect = 1'b1;
    redirect_addr = 32'hFFFF_FFFC;
    #1;
    chk("s5_pc_next_redir", pc_next, 32'hFFFF_FFFC);
    cyc();
    redirect = 1'b0;
    #1;
    chk("s5_pc_next_wrap", pc_next, 32'h0000_0000);
    cyc(); #1;
    chk("s5_addr_top", imem_addr, 32'hFFFF_FFFC);
    cyc(); cyc(); #1;
    chk("s5_addr_zero", imem_addr, 32'h0000_0000);
    chk("s5_inst_pc", inst_pc, 32'hFFFF_FFFC);
    chk("s5_inst", inst, 32'h2152_FFFC);

    // reset in WAIT, stale rvalid arrives after reset
    do_reset(1'b1);
    rv_en = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rv_en = 1'b1;
    #1;
    chk("s6_valid_c0", 32'(inst_valid), 32'h0);
    chk("s6_req_c0", 32'(imem_req), 32'h0);
    chk("s6_pc_next", pc_next, 32'h0000_1004);
    cyc(); #1;
    chk("s6_valid_c1", 32'(inst_valid), 32'h0);
    chk("s6_addr", imem_addr, 32'h0000_1000);
    cyc(); cyc(); #1;
    chk("s6_inst_pc", inst_pc, 32'h0000_1000);
    chk("s6_inst", inst, 32'hDEAD_1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
